// File: rtl/fpu_div_issue_pkg.sv
// rtl/fpu_div_issue_pkg.sv - shared types and constants for the fpuDiv issue stage
package fpu_div_issue_pkg;

    typedef logic [15:0] fp16_t;
    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } condCode_t;

    typedef struct packed {
        logic invalid;
        logic divByZero;
        logic overflow;
        logic underflow;
        logic inexact;
    } opStatusFlag_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        BUSY,
        HOLD
    } fpDivIssueState_t;

    localparam fp16_t FP16_QNAN = 16'h7E00;
    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

    // Canonical quiet NaN for the supported operand widths, right-aligned.
    function automatic logic [31:0] qnanBits(input int width);
        return (width == 32) ? FP32_QNAN : {16'h0000, FP16_QNAN};
    endfunction

endpackage

// File: rtl/fpu_div_issue_fsm.sv
// rtl/fpu_div_issue_fsm.sv - sequencing FSM and watchdog for the fpuDiv issue stage
module fpu_div_issue_fsm
    import fpu_div_issue_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic inValid,
    input  logic outReady,
    input  logic divDone,
    output logic inReady,
    output logic divReset,
    output logic divStart,
    output logic outValid,
    output logic loadOps,
    output logic capture,
    output logic abort
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = {CW{1'b1}};

    fpDivIssueState_t state;
    fpDivIssueState_t nextState;
    logic [CW-1:0]    watchdog;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            watchdog <= '0;
        end else if (state == LAUNCH) begin
            watchdog <= '0;
        end else if (state == BUSY && watchdog != SAT) begin
            watchdog <= watchdog + 1'b1;
        end
    end

    assign inReady  = (state == IDLE) && !reset;
    assign divReset = reset || (state == CLEAR);
    assign divStart = (state == LAUNCH);
    assign outValid = (state == HOLD);

    always_comb begin
        nextState = state;
        loadOps   = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (inValid && inReady) begin
                    loadOps   = 1'b1;
                    nextState = CLEAR;
                end
            end
            CLEAR:  nextState = LAUNCH;
            LAUNCH: nextState = BUSY;
            BUSY: begin
                // A completion seen on the watchdog's last cycle still counts.
                if (divDone) begin
                    capture   = 1'b1;
                    nextState = HOLD;
                end else if (watchdog == LAST) begin
                    abort     = 1'b1;
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (outReady) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: rtl/fpu_div_issue.sv
// rtl/fpu_div_issue.sv - operand/result registers around the fpuDiv issue FSM
module fpu_div_issue
    import fpu_div_issue_pkg::*;
#(
    parameter type FP_T    = fp16_t,
    parameter int  TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inValid,
    output logic          inReady,
    input  FP_T           opA,
    input  FP_T           opB,
    output logic          outValid,
    input  logic          outReady,
    output FP_T           result,
    output condCode_t     resCond,
    output opStatusFlag_t resFlags,
    output logic          timeout,
    output FP_T           divIn1,
    output FP_T           divIn2,
    output logic          divStart,
    output logic          divReset,
    input  FP_T           divOut,
    input  condCode_t     divCond,
    input  opStatusFlag_t divFlags,
    input  logic          divDone
);

    localparam FP_T QNAN = FP_T'(qnanBits($bits(FP_T)));

    FP_T  operA;
    FP_T  operB;
    logic loadOps;
    logic capture;
    logic abort;

    fpu_div_issue_fsm #(
        .TIMEOUT(TIMEOUT)
    ) fsm (
        .clock   (clock),
        .reset   (reset),
        .inValid (inValid),
        .outReady(outReady),
        .divDone (divDone),
        .inReady (inReady),
        .divReset(divReset),
        .divStart(divStart),
        .outValid(outValid),
        .loadOps (loadOps),
        .capture (capture),
        .abort   (abort)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            operA    <= '0;
            operB    <= '0;
            result   <= '0;
            resCond  <= '0;
            resFlags <= '0;
            timeout  <= 1'b0;
        end else begin
            if (loadOps) begin
                operA <= opA;
                operB <= opB;
            end
            if (capture) begin
                result   <= divOut;
                resCond  <= divCond;
                resFlags <= divFlags;
                timeout  <= 1'b0;
            end else if (abort) begin
                result   <= QNAN;
                resCond  <= '0;
                resFlags <= '0;
                timeout  <= 1'b1;
            end
        end
    end

    assign divIn1 = operA;
    assign divIn2 = operB;

endmodule

// File: tb/tb_fpu_div_issue.sv
// tb/tb_fpu_div_issue.sv - directed scoreboard bench for fpu_div_issue with a behavioural divider
module tb_fpu_div_issue;
    import fpu_div_issue_pkg::*;

    localparam int TO = 8;

    typedef struct packed {
        fp16_t         result;
        condCode_t     cond;
        opStatusFlag_t flags;
        logic          tmo;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          inValid;
    logic          inReady;
    fp16_t         opA;
    fp16_t         opB;
    logic          outValid;
    logic          outReady;
    fp16_t         result;
    condCode_t     resCond;
    opStatusFlag_t resFlags;
    logic          timeout;
    fp16_t         divIn1;
    fp16_t         divIn2;
    logic          divStart;
    logic          divReset;
    fp16_t         divOut;
    condCode_t     divCond;
    opStatusFlag_t divFlags;
    logic          divDone;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    int   resetPulses = 0;
    int   startPulses = 0;
    int   divLatency = 3;
    bit   divHung = 0;
    logic divBusy;
    int   divCnt;
    exp_t divCalc;
    exp_t sb[$];

    fpu_div_issue #(
        .FP_T   (fp16_t),
        .TIMEOUT(TO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .inValid (inValid),
        .inReady (inReady),
        .opA     (opA),
        .opB     (opB),
        .outValid(outValid),
        .outReady(outReady),
        .result  (result),
        .resCond (resCond),
        .resFlags(resFlags),
        .timeout (timeout),
        .divIn1  (divIn1),
        .divIn2  (divIn2),
        .divStart(divStart),
        .divReset(divReset),
        .divOut  (divOut),
        .divCond (divCond),
        .divFlags(divFlags),
        .divDone (divDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t modelDiv(input fp16_t a, input fp16_t b);
        exp_t e;
        e = '0;
        case ({a, b})
            32'h4600_4000: e.result = 16'h4200;
            32'h3C00_3C00: e.result = 16'h3C00;
            32'h4400_4000: e.result = 16'h4000;
            32'hC600_4000: e.result = 16'hC200;
            32'h3C00_4200: begin
                e.result = 16'h3555;
                e.flags.inexact = 1'b1;
            end
            default: begin
                e.result = 16'h7E00;
                e.flags.invalid = 1'b1;
            end
        endcase
        e.cond.n = e.result[15];
        e.cond.z = (e.result[14:0] == 15'd0);
        return e;
    endfunction

    assign divCalc = modelDiv(divIn1, divIn2);

    // Divider model: sticky done until its reset, like the real fpuDiv.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (divReset && !reset) resetPulses <= resetPulses + 1;
        if (divStart) startPulses <= startPulses + 1;
        if (divReset) begin
            divBusy  <= 1'b0;
            divCnt   <= 0;
            divDone  <= 1'b0;
            divOut   <= '0;
            divCond  <= '0;
            divFlags <= '0;
        end else if (divStart) begin
            divBusy <= 1'b1;
            divCnt  <= 0;
            divDone <= 1'b0;
        end else if (divBusy && !divHung) begin
            if (divCnt == divLatency - 1) begin
                divBusy  <= 1'b0;
                divDone  <= 1'b1;
                divOut   <= divCalc.result;
                divCond  <= divCalc.cond;
                divFlags <= divCalc.flags;
            end else begin
                divCnt <= divCnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode: 0 no expectation, 1 divider result, 2 watchdog abort
    task automatic issue(input fp16_t a, input fp16_t b, input int mode);
        exp_t e;
        @(negedge clock);
        check("inReady_before_issue", 32'(inReady), 32'd1);
        opA = a;
        opB = b;
        inValid = 1'b1;
        if (mode == 1) sb.push_back(modelDiv(a, b));
        if (mode == 2) begin
            e = '0;
            e.result = FP16_QNAN;
            e.tmo = 1'b1;
            sb.push_back(e);
        end
        @(negedge clock);
        acceptCyc = cyc;
        inValid = 1'b0;
        opA = 16'hDEAD;
        opB = 16'hBEEF;
    endtask

    task automatic waitOut(input string tag, input int expLat);
        int n;
        n = 0;
        while (!outValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_outValid"}, 32'(outValid), 32'd1);
        if (expLat > 0) check({tag, "_latency"}, 32'(cyc - acceptCyc + 1), 32'(expLat));
    endtask

    task automatic popAndRelease(input string tag);
        exp_t e;
        check({tag, "_sbNotEmpty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.result));
            check({tag, "_resCond"}, 32'(resCond), 32'(e.cond));
            check({tag, "_resFlags"}, 32'(resFlags), 32'(e.flags));
            check({tag, "_timeout"}, 32'(timeout), 32'(e.tmo));
        end
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit   stable;
        bit   quiet;
        int   sp;
        fp16_t snap;

        reset = 1'b1;
        inValid = 1'b0;
        outReady = 1'b0;
        opA = '0;
        opB = '0;
        repeat (3) @(negedge clock);
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_resCond", 32'(resCond), 32'd0);
        check("rst_resFlags", 32'(resFlags), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_divStart", 32'(divStart), 32'd0);
        check("rst_divReset", 32'(divReset), 32'd1);
        check("rst_divIn1", 32'(divIn1), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_inReady", 32'(inReady), 32'd1);
        check("post_rst_divReset", 32'(divReset), 32'd0);

        // 6.0 / 2.0 with a cycle-by-cycle look at the launch sequence
        issue(16'h4600, 16'h4000, 1);
        check("t1_clear_divReset", 32'(divReset), 32'd1);
        check("t1_clear_divStart", 32'(divStart), 32'd0);
        check("t1_clear_inReady", 32'(inReady), 32'd0);
        check("t1_divIn1_held", 32'(divIn1), 32'h4600);
        check("t1_divIn2_held", 32'(divIn2), 32'h4000);
        @(negedge clock);
        check("t1_launch_divReset", 32'(divReset), 32'd0);
        check("t1_launch_divStart", 32'(divStart), 32'd1);
        @(negedge clock);
        check("t1_busy_divStart", 32'(divStart), 32'd0);
        check("t1_busy_divIn1", 32'(divIn1), 32'h4600);
        waitOut("t1", 4 + 3);
        popAndRelease("t1");
        check("t1_resetPulses", 32'(resetPulses), 32'd1);
        check("t1_startPulses", 32'(startPulses), 32'd1);

        // back-to-back, each with its own CLEAR
        issue(16'h3C00, 16'h3C00, 1);
        waitOut("b2b_a", 7);
        popAndRelease("b2b_a");
        issue(16'h4400, 16'h4000, 1);
        waitOut("b2b_b", 7);
        popAndRelease("b2b_b");
        check("b2b_resetPulses", 32'(resetPulses), 32'd3);
        check("b2b_startPulses", 32'(startPulses), 32'd3);

        // negative quotient and an inexact one
        issue(16'hC600, 16'h4000, 1);
        waitOut("neg", 7);
        popAndRelease("neg");
        divLatency = 5;
        issue(16'h3C00, 16'h4200, 1);
        waitOut("inexact", 4 + 5);
        popAndRelease("inexact");
        divLatency = 3;

        // backpressure
        issue(16'h4600, 16'h4000, 1);
        waitOut("bp", 7);
        snap = result;
        sp = startPulses;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (result !== snap || inReady !== 1'b0 || outValid !== 1'b1) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_noStart", 32'(startPulses), 32'(sp));
        popAndRelease("bp");
        check("bp_idle_inReady", 32'(inReady), 32'd1);
        check("bp_idle_outValid", 32'(outValid), 32'd0);

        // hung divider: watchdog abort after TO busy cycles
        divHung = 1'b1;
        issue(16'h4600, 16'h4000, 2);
        waitOut("tmo", 4 + TO - 1);
        popAndRelease("tmo");
        divHung = 1'b0;

        // done lands on the watchdog's final cycle
        divLatency = TO - 1;
        issue(16'h4600, 16'h4000, 1);
        waitOut("collide", 4 + TO - 1);
        popAndRelease("collide");
        divLatency = 3;

        // reset while BUSY
        divHung = 1'b1;
        issue(16'h4600, 16'h4000, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rbusy_outValid", 32'(outValid), 32'd0);
        check("rbusy_divReset", 32'(divReset), 32'd1);
        check("rbusy_divStart", 32'(divStart), 32'd0);
        reset = 1'b0;
        divHung = 1'b0;
        quiet = 1'b1;
        repeat (TO + 6) begin
            @(negedge clock);
            if (outValid !== 1'b0 || inReady !== 1'b1) quiet = 1'b0;
        end
        check("rbusy_quiet_idle", 32'(quiet), 32'd1);
        issue(16'h4600, 16'h4000, 1);
        waitOut("rbusy_after", 7);
        popAndRelease("rbusy_after");

        // reset while HOLD discards the pending result
        issue(16'h3C00, 16'h3C00, 0);
        waitOut("rhold", 7);
        reset = 1'b1;
        @(negedge clock);
        check("rhold_outValid", 32'(outValid), 32'd0);
        check("rhold_result", 32'(result), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        issue(16'h4400, 16'h4000, 1);
        waitOut("final", 7);
        popAndRelease("final");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
